// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN output path: frame geometry, bus widths,
// writer FSM encoding and the 8-bit channel ceiling.
package cnn_pkg;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned WIDTH  = 480;
    localparam int unsigned HEIGHT = 272;

    localparam logic [7:0] CH_MAX = 8'hFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } wr_state_e;

endpackage

// File: rtl/sat_u8.sv
// Saturates one signed conv channel result into an unsigned 8-bit pixel value.
module sat_u8
    import cnn_pkg::*;
#(
    parameter int unsigned SUM_W = 12
) (
    input  logic signed [SUM_W-1:0] sum_i,
    output logic        [7:0]       pix_o
);

    logic signed [31:0] wide;

    assign wide = {{(32 - SUM_W){sum_i[SUM_W-1]}}, sum_i};

    always_comb begin
        pix_o = wide[7:0];
        if (wide < 32'sd0) begin
            pix_o = 8'd0;
        end else if (wide > $signed({24'd0, CH_MAX})) begin
            pix_o = CH_MAX;
        end
    end

endmodule

// File: rtl/outbuf_writer.sv
// Streams clamped RGB888 pixels of one frame into the output BRAM, one write
// per accepted conv result, and tracks frame completion and stray inputs.
module outbuf_writer
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = cnn_pkg::DATA_W,
    parameter int unsigned ADDR_W = cnn_pkg::ADDR_W,
    parameter int unsigned WIDTH  = cnn_pkg::WIDTH,
    parameter int unsigned HEIGHT = cnn_pkg::HEIGHT,
    parameter int unsigned SUM_W  = 12
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iEn,
    input  logic                    iStart,
    input  logic                    iValid,
    input  logic signed [SUM_W-1:0] iR,
    input  logic signed [SUM_W-1:0] iG,
    input  logic signed [SUM_W-1:0] iB,
    output logic                    oCs,
    output logic                    oWe,
    output logic [ADDR_W-1:0]       oAddr,
    output logic [DATA_W-1:0]       oData,
    output logic                    oBusy,
    output logic                    oDone,
    output logic                    oOverrun,
    output logic [7:0]              oFrameCnt
);

    localparam int unsigned      DEPTH = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic [7:0] r_sat, g_sat, b_sat;

    sat_u8 #(.SUM_W(SUM_W)) u_sat_r (.sum_i(iR), .pix_o(r_sat));
    sat_u8 #(.SUM_W(SUM_W)) u_sat_g (.sum_i(iG), .pix_o(g_sat));
    sat_u8 #(.SUM_W(SUM_W)) u_sat_b (.sum_i(iB), .pix_o(b_sat));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;

        if (iEn) begin
            unique case (state_q)
                StRun: begin
                    if (iValid) begin
                        wr_d   = 1'b1;
                        addr_d = cnt_q;
                        data_d = DATA_W'({r_sat, g_sat, b_sat});
                        if (cnt_q == LAST) begin
                            cnt_d       = '0;
                            state_d     = StDone;
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end else begin
                            cnt_d = cnt_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    if (iStart) begin
                        cnt_d     = '0;
                        state_d   = StRun;
                        overrun_d = 1'b0;
                    end
                    // A stray valid wins over the start-clear so it is never lost.
                    if (iValid) begin
                        overrun_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign oCs       = wr_q;
    assign oWe       = wr_q;
    assign oAddr     = addr_q;
    assign oData     = data_q;
    assign oBusy     = (state_q == StRun);
    assign oDone     = (state_q == StDone);
    assign oOverrun  = overrun_q;
    assign oFrameCnt = frame_cnt_q;

endmodule

// File: tb/tb_outbuf_writer.sv
// Randomised and directed bench for outbuf_writer on a 4x3 frame, checked
// against a frame-level reference model.
module tb_outbuf_writer;

    localparam int unsigned W      = 4;
    localparam int unsigned H      = 3;
    localparam int unsigned NPIX   = W * H;
    localparam int unsigned SUM_W  = 12;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 24;

    logic                    iClk;
    logic                    iRst;
    logic                    iEn;
    logic                    iStart;
    logic                    iValid;
    logic signed [SUM_W-1:0] iR, iG, iB;
    logic                    oCs, oWe, oBusy, oDone, oOverrun;
    logic [ADDR_W-1:0]       oAddr;
    logic [DATA_W-1:0]       oData;
    logic [7:0]              oFrameCnt;

    outbuf_writer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .WIDTH (W),
        .HEIGHT(H),
        .SUM_W (SUM_W)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iEn      (iEn),
        .iStart   (iStart),
        .iValid   (iValid),
        .iR       (iR),
        .iG       (iG),
        .iB       (iB),
        .oCs      (oCs),
        .oWe      (oWe),
        .oAddr    (oAddr),
        .oData    (oData),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oOverrun (oOverrun),
        .oFrameCnt(oFrameCnt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: "mode" is 0 = waiting for a frame, 1 = filling, 2 = frame complete.
    int          m_mode;
    int          m_pix;
    int          m_frames;
    bit          m_ovr;
    bit          m_wr;
    int          m_addr;
    logic [23:0] m_data;

    function automatic logic [7:0] clamp(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pix = 0; m_frames = 0; m_ovr = 0; m_wr = 0;
        m_addr = 0; m_data = '0;
    endtask

    task automatic model_step(input bit en, input bit start, input bit valid,
                              input int r, input int g, input int b);
        m_wr = 0;
        if (!en) return;
        if (m_mode == 1) begin
            if (valid) begin
                m_wr   = 1;
                m_addr = m_pix;
                m_data = {clamp(r), clamp(g), clamp(b)};
                m_pix  = m_pix + 1;
                if (m_pix == NPIX) begin
                    m_pix    = 0;
                    m_mode   = 2;
                    m_frames = (m_frames + 1) % 256;
                end
            end
        end else begin
            if (start) begin
                m_mode = 1;
                m_pix  = 0;
                m_ovr  = 0;
            end
            if (valid) m_ovr = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cs"},   32'(oCs),       32'(m_wr));
        check({tag, ".we"},   32'(oWe),       32'(m_wr));
        check({tag, ".addr"}, 32'(oAddr),     32'(m_addr));
        check({tag, ".data"}, 32'(oData),     32'(m_data));
        check({tag, ".busy"}, 32'(oBusy),     32'(m_mode == 1));
        check({tag, ".done"}, 32'(oDone),     32'(m_mode == 2));
        check({tag, ".ovr"},  32'(oOverrun),  32'(m_ovr));
        check({tag, ".fcnt"}, 32'(oFrameCnt), 32'(m_frames));
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input string tag, input bit en, input bit start, input bit valid,
                        input int r, input int g, input int b);
        @(negedge iClk);
        iEn = en; iStart = start; iValid = valid;
        iR = SUM_W'(r); iG = SUM_W'(g); iB = SUM_W'(b);
        @(posedge iClk);
        #1;
        model_step(en, start, valid, r, g, b);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge iClk);
        #2;
        iRst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge iClk);
        iRst = 1'b1;
    endtask

    function automatic int rand_sum();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 255));
            1:       return int'($urandom_range(0, 20)) - 10;
            2:       return 245 + int'($urandom_range(0, 20));
            default: return int'($urandom_range(0, 4095)) - 2048;
        endcase
    endfunction

    initial begin
        iRst = 1'b1; iEn = 1'b0; iStart = 1'b0; iValid = 1'b0;
        iR = '0; iG = '0; iB = '0;
        model_reset();

        do_reset("reset");

        // Stray valid while idle, then start clears the flag.
        step("idle_valid", 1, 0, 1, 10, 20, 30);
        check("idle_valid.no_we", 32'(oWe), 32'd0);
        check("idle_valid.ovr", 32'(oOverrun), 32'd1);
        step("start", 1, 1, 0, 0, 0, 0);
        check("start.ovr_clr", 32'(oOverrun), 32'd0);

        // Clamp corner cases on pixel 0.
        step("clamp", 1, 0, 1, -5, 300, 127);
        check("clamp.data", 32'(oData), 32'h0000FF7F);
        for (int i = 1; i < 5; i++) step("fill", 1, 0, 1, i * 40, -i, 256 + i);

        // Enable low for three cycles: nothing moves.
        for (int i = 0; i < 3; i++) step("en_low", 0, 1, 1, 1, 2, 3);
        step("resume", 1, 0, 1, 0, 255, 256);
        check("resume.addr", 32'(oAddr), 32'd5);
        for (int i = 6; i < int'(NPIX); i++) step("fill", 1, 0, 1, i, i, i);
        check("frame1.addr", 32'(oAddr), 32'(NPIX - 1));
        step("done_idle", 1, 0, 0, 0, 0, 0);
        check("frame1.done", 32'(oDone), 32'd1);
        check("frame1.fcnt", 32'(oFrameCnt), 32'd1);

        // Restart from DONE with a simultaneous valid: dropped, flagged.
        step("restart", 1, 1, 1, 9, 9, 9);
        check("restart.ovr", 32'(oOverrun), 32'd1);
        for (int i = 0; i < int'(NPIX); i++) step("frame2", 1, 0, 1, 3 * i, -i, 100);
        check("frame2.fcnt", 32'(oFrameCnt), 32'd2);

        // Reset mid-frame after address 5, then first cycle after release writes nothing.
        step("start3", 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("frame3", 1, 0, 1, i, i, i);
        do_reset("midreset");
        step("post_rst", 1, 0, 1, 1, 1, 1);
        step("start4", 1, 1, 0, 0, 0, 0);
        step("frame4", 1, 0, 1, 7, 7, 7);
        check("frame4.addr0", 32'(oAddr), 32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), rand_sum(), rand_sum(), rand_sum());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
